// File: rtl/codec_config_sequencer_pkg.sv
// Shared types and the WM8731 microphone-capture write table.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitAck,
    StGap,
    StDone,
    StError
  } cfg_state_t;

  // 7-bit I2C address of the WM8731 (8'h34 on the wire for a write).
  localparam logic [6:0] WM8731_DEV_ADDR = 7'h1A;

  localparam int unsigned CFG_TABLE_LEN = 9;

  // Packs to the 16-bit command word {addr, data}.
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } cfg_entry_t;

  localparam cfg_entry_t WM8731_CFG_TABLE [CFG_TABLE_LEN] = '{
    '{addr: 7'd15, data: 9'h000},  // reset
    '{addr: 7'd0,  data: 9'h017},  // left line-in level
    '{addr: 7'd1,  data: 9'h017},  // right line-in level
    '{addr: 7'd4,  data: 9'h015},  // mic select, boost, bypass off
    '{addr: 7'd5,  data: 9'h000},  // digital path
    '{addr: 7'd6,  data: 9'h000},  // power up all
    '{addr: 7'd7,  data: 9'h042},  // master, I2S, 16-bit
    '{addr: 7'd8,  data: 9'h000},  // sampling control
    '{addr: 7'd9,  data: 9'h001}   // active
  };

endpackage

// File: rtl/codec_config_sequencer_if.sv
// Command/result handshake between the config sequencer and the i2c_master.
interface codec_config_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_dev_addr;
  logic [15:0] cmd_word;
  logic        ack_valid;
  logic        ack_nack;

  modport master (
    output cmd_valid,
    output cmd_dev_addr,
    output cmd_word,
    input  cmd_ready,
    input  ack_valid,
    input  ack_nack
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dev_addr,
    input  cmd_word,
    output cmd_ready,
    output ack_valid,
    output ack_nack
  );
endinterface

// File: rtl/codec_config_sequencer_wait_timer.sv
// Loadable down-counter used for both the inter-write gap and the ACK timeout.
module cfg_wait_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] value_o,
  output logic             expired_o
);

  logic [Width-1:0] count_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign value_o   = count_q;
  assign expired_o = (count_q == '0);

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the WM8731 write table, issuing one command per entry to the i2c_master,
// retrying on NACK/timeout and reporting done or error.
module codec_config_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int unsigned NUM_WRITES     = CFG_TABLE_LEN,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  codec_config_sequencer_if.master  bus,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [3:0]                entry_idx,
  output logic [1:0]                retry_cnt
);

  localparam int unsigned TimerWidth = 8;
  // A load of N-1 expires on the Nth cycle after the load edge.
  localparam logic [TimerWidth-1:0] TimeoutLoad = TimerWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerWidth-1:0] GapLoad     = TimerWidth'(GAP_CYCLES - 1);
  localparam logic [3:0]            LastIdx     = 4'(NUM_WRITES - 1);

  cfg_state_t      state_q;
  logic            cmd_valid_q;
  logic [15:0]     cmd_word_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic [3:0]      entry_idx_q;
  logic [1:0]      retry_cnt_q;
  logic            success_q;
  logic            auto_start_q;

  logic                  timer_load;
  logic [TimerWidth-1:0] timer_load_val;
  logic [TimerWidth-1:0] unused_timer_value;
  logic                  timer_expired;

  logic ack_ok;
  logic attempt_failed;

  // ack_valid outranks a timeout landing on the same cycle.
  assign ack_ok         = bus.ack_valid & ~bus.ack_nack;
  assign attempt_failed = bus.ack_valid ? bus.ack_nack : timer_expired;

  cfg_wait_timer #(
    .Width (TimerWidth)
  ) u_wait_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .value_o    (unused_timer_value),
    .expired_o  (timer_expired)
  );

  // Arm the timeout on command acceptance and the gap on any write result.
  always_comb begin
    timer_load     = 1'b0;
    timer_load_val = '0;
    if (state_q == StSend && bus.cmd_ready) begin
      timer_load     = 1'b1;
      timer_load_val = TimeoutLoad;
    end else if (state_q == StWaitAck && (bus.ack_valid || timer_expired)) begin
      timer_load     = 1'b1;
      timer_load_val = GapLoad;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cmd_valid_q  <= 1'b0;
      cmd_word_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      entry_idx_q  <= '0;
      retry_cnt_q  <= '0;
      success_q    <= 1'b0;
      // First cycle out of reset acts as a start so the codec configures at power-up.
      auto_start_q <= 1'b1;
    end else begin
      auto_start_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start || auto_start_q) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            entry_idx_q <= '0;
            retry_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          cmd_word_q  <= WM8731_CFG_TABLE[entry_idx_q];
          cmd_valid_q <= 1'b1;
          state_q     <= StSend;
        end
        StSend: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (ack_ok) begin
            retry_cnt_q <= '0;
            success_q   <= 1'b1;
            state_q     <= StGap;
          end else if (attempt_failed) begin
            if (32'(retry_cnt_q) < MAX_RETRIES) begin
              retry_cnt_q <= retry_cnt_q + 2'd1;
              success_q   <= 1'b0;
              state_q     <= StGap;
            end else begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StError;
            end
          end
        end
        StGap: begin
          if (timer_expired) begin
            if (success_q && entry_idx_q == LastIdx) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StDone;
            end else begin
              if (success_q) begin
                entry_idx_q <= entry_idx_q + 4'd1;
              end
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_word     = cmd_word_q;
  assign bus.cmd_dev_addr = WM8731_DEV_ADDR;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign entry_idx        = entry_idx_q;
  assign retry_cnt        = retry_cnt_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a behavioural i2c_master model.
module tb_codec_config_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [3:0] entry_idx;
  logic [1:0] retry_cnt;

  int checks = 0;
  int failures = 0;

  codec_config_sequencer_if bus ();

  codec_config_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .entry_idx (entry_idx),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  // Expected command words: {reg_addr[6:0], reg_data[8:0]}.
  logic [15:0] exp_tab [9] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0815, 16'h0A00,
                               16'h0C00, 16'h0E42, 16'h1000, 16'h1201};

  // Master model knobs.
  int          ack_delay = 10;
  logic [15:0] nack_word = 16'h0000;
  int          nack_left = 0;   // -1 = NACK forever
  logic [15:0] hold_word = 16'hFFFF;
  int          hold_left = 0;
  int          ack_cnt = 0;
  logic [15:0] last_word = 16'h0000;
  logic [15:0] log_words [$];
  logic [1:0]  log_rc [$];

  // i2c_master model: everything happens on the falling edge.
  initial begin
    bus.cmd_ready = 1'b1;
    bus.ack_valid = 1'b0;
    bus.ack_nack  = 1'b0;
    forever begin
      @(negedge clk);
      bus.ack_valid = 1'b0;
      bus.ack_nack  = 1'b0;
      if (!reset_n) begin
        ack_cnt = 0;
        bus.cmd_ready = 1'b1;
      end else begin
        if (ack_cnt > 0) begin
          ack_cnt--;
          if (ack_cnt == 0) begin
            bus.ack_valid = 1'b1;
            if (last_word == nack_word && nack_left != 0) begin
              bus.ack_nack = 1'b1;
              if (nack_left > 0) nack_left--;
            end
          end
        end
        if (bus.cmd_valid && bus.cmd_word == hold_word && hold_left > 0) begin
          bus.cmd_ready = 1'b0;
          hold_left--;
        end else begin
          bus.cmd_ready = 1'b1;
          if (bus.cmd_valid) begin
            log_words.push_back(bus.cmd_word);
            log_rc.push_back(retry_cnt);
            last_word = bus.cmd_word;
            ack_cnt = ack_delay;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
  endtask

  // Release reset and run until done/error; cyc = posedges after release.
  task automatic run_seq(input int start_at, output int cyc, output int hold_cyc);
    log_words.delete();
    log_rc.delete();
    reset_n = 1'b1;
    cyc = 0;
    hold_cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk); #1;
      start = (cyc == start_at);
      if (bus.cmd_valid && bus.cmd_word == hold_word) hold_cyc++;
      if (done || error) break;
    end
    start = 1'b0;
    if (!(done || error)) begin
      checks++; failures++;
      $display("FAIL run_seq_timeout done/error never seen after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL rst_cmd_valid got=%b want=0", bus.cmd_valid); end
    checks++; if (bus.cmd_word !== 16'h0000) begin failures++; $display("FAIL rst_cmd_word got=%h want=0000", bus.cmd_word); end
    checks++; if (bus.cmd_dev_addr !== 7'h1A) begin failures++; $display("FAIL dev_addr got=%h want=1a", bus.cmd_dev_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b want=0", error); end
    checks++; if (entry_idx !== 4'd0) begin failures++; $display("FAIL rst_entry_idx got=%0d want=0", entry_idx); end
    checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL rst_retry_cnt got=%0d want=0", retry_cnt); end
  endtask

  task automatic test_power_up();
    int cyc, hc;
    reset_dut();
    run_seq(0, cyc, hc);
    // 9 entries x (LOAD + SEND + 10 ack + 4 gap) = 144 cycles after the auto-start edge.
    checks++; if (cyc !== 145) begin failures++; $display("FAIL pu_latency got=%0d want=145", cyc); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL pu_status done=%b error=%b want 1/0", done, error); end
    checks++; if (busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin failures++; $display("FAIL pu_idle busy=%b cmd_valid=%b want 0/0", busy, bus.cmd_valid); end
    checks++; if (log_words.size() !== 9) begin failures++; $display("FAIL pu_count got=%0d want=9", log_words.size()); end
    for (int i = 0; i < 9 && i < log_words.size(); i++) begin
      checks++; if (log_words[i] !== exp_tab[i] || log_rc[i] !== 2'd0) begin
        failures++; $display("FAIL pu_word[%0d] got=%h rc=%0d want=%h rc=0", i, log_words[i], log_rc[i], exp_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    log_words.delete();
    log_rc.delete();
    @(negedge clk); #1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_restart done=%b busy=%b want 0/1", done, busy); end
    cyc = 0;
    while (cyc < 2000 && !(done || error)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk); #1;
    end
    // start edge counts as cycle 0 here, so done lands 144 edges later.
    checks++; if (cyc !== 144 || done !== 1'b1) begin failures++; $display("FAIL b2b_latency got=%0d done=%b want=144 done=1", cyc, done); end
    checks++; if (log_words.size() !== 9) begin failures++; $display("FAIL b2b_count got=%0d want=9", log_words.size()); end
    for (int i = 0; i < 9 && i < log_words.size(); i++) begin
      checks++; if (log_words[i] !== exp_tab[i]) begin failures++; $display("FAIL b2b_word[%0d] got=%h want=%h", i, log_words[i], exp_tab[i]); end
    end
  endtask

  task automatic test_nack_retry();
    int cyc, hc;
    logic [15:0] ew [$];
    logic [1:0]  er [$];
    for (int i = 0; i < 9; i++) begin
      ew.push_back(exp_tab[i]);
      er.push_back(2'd0);
      if (i == 3) begin
        ew.push_back(exp_tab[3]); er.push_back(2'd1);
        ew.push_back(exp_tab[3]); er.push_back(2'd2);
      end
    end
    nack_word = 16'h0815;
    nack_left = 2;
    reset_dut();
    run_seq(0, cyc, hc);
    // Two extra 16-cycle attempts on entry 3.
    checks++; if (cyc !== 177) begin failures++; $display("FAIL nack_latency got=%0d want=177", cyc); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL nack_status done=%b error=%b want 1/0", done, error); end
    checks++; if (retry_cnt !== 2'd0) begin failures++; $display("FAIL nack_rc_final got=%0d want=0", retry_cnt); end
    checks++; if (log_words.size() !== 11) begin failures++; $display("FAIL nack_count got=%0d want=11", log_words.size()); end
    for (int i = 0; i < 11 && i < log_words.size(); i++) begin
      checks++; if (log_words[i] !== ew[i] || log_rc[i] !== er[i]) begin
        failures++; $display("FAIL nack_send[%0d] got=%h rc=%0d want=%h rc=%0d", i, log_words[i], log_rc[i], ew[i], er[i]);
      end
    end
    nack_left = 0;
  endtask

  task automatic test_abort();
    int cyc, hc;
    logic [15:0] ew [9] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0815, 16'h0A00,
                            16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00};
    logic [1:0]  er [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    nack_word = 16'h0C00;
    nack_left = -1;
    reset_dut();
    run_seq(0, cyc, hc);
    checks++; if (cyc !== 141) begin failures++; $display("FAIL abort_latency got=%0d want=141", cyc); end
    checks++; if (error !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_status error=%b done=%b want 1/0", error, done); end
    checks++; if (entry_idx !== 4'd5) begin failures++; $display("FAIL abort_idx got=%0d want=5", entry_idx); end
    checks++; if (retry_cnt !== 2'd3) begin failures++; $display("FAIL abort_rc got=%0d want=3", retry_cnt); end
    checks++; if (log_words.size() !== 9) begin failures++; $display("FAIL abort_count got=%0d want=9", log_words.size()); end
    for (int i = 0; i < 9 && i < log_words.size(); i++) begin
      checks++; if (log_words[i] !== ew[i] || log_rc[i] !== er[i]) begin
        failures++; $display("FAIL abort_send[%0d] got=%h rc=%0d want=%h rc=%0d", i, log_words[i], log_rc[i], ew[i], er[i]);
      end
    end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (log_words.size() !== 9 || bus.cmd_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL abort_quiet count=%0d cmd_valid=%b busy=%b want 9/0/0", log_words.size(), bus.cmd_valid, busy);
    end
    nack_left = 0;
  endtask

  task automatic test_timeout();
    int cyc, hc;
    // Ack arrives 66 cycles after accept: after the 64-cycle timeout, inside the gap.
    ack_delay = 66;
    reset_dut();
    run_seq(0, cyc, hc);
    // Attempts every 70 cycles from edge 3; last timeout fires at 213 + 64.
    checks++; if (cyc !== 277) begin failures++; $display("FAIL to_latency got=%0d want=277", cyc); end
    checks++; if (error !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL to_status error=%b done=%b want 1/0", error, done); end
    checks++; if (entry_idx !== 4'd0 || retry_cnt !== 2'd3) begin failures++; $display("FAIL to_idx idx=%0d rc=%0d want 0/3", entry_idx, retry_cnt); end
    checks++; if (log_words.size() !== 4) begin failures++; $display("FAIL to_count got=%0d want=4", log_words.size()); end
    for (int i = 0; i < 4 && i < log_words.size(); i++) begin
      checks++; if (log_words[i] !== 16'h1E00 || log_rc[i] !== 2'(i)) begin
        failures++; $display("FAIL to_send[%0d] got=%h rc=%0d want=1e00 rc=%0d", i, log_words[i], log_rc[i], i);
      end
    end
    ack_delay = 10;
  endtask

  task automatic test_ready_hold();
    int cyc, hc;
    hold_word = 16'h0017;
    hold_left = 20;
    reset_dut();
    run_seq(0, cyc, hc);
    // 20 stalled cycles plus the accept cycle with the same word on the bus.
    checks++; if (hc !== 21) begin failures++; $display("FAIL hold_cycles got=%0d want=21", hc); end
    checks++; if (cyc !== 165) begin failures++; $display("FAIL hold_latency got=%0d want=165", cyc); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL hold_status done=%b error=%b want 1/0", done, error); end
    checks++; if (log_words.size() !== 9) begin failures++; $display("FAIL hold_count got=%0d want=9", log_words.size()); end
    for (int i = 0; i < 9 && i < log_words.size(); i++) begin
      checks++; if (log_words[i] !== exp_tab[i] || log_rc[i] !== 2'd0) begin
        failures++; $display("FAIL hold_send[%0d] got=%h rc=%0d want=%h rc=0", i, log_words[i], log_rc[i], exp_tab[i]);
      end
    end
    hold_left = 0;
    hold_word = 16'hFFFF;
  endtask

  task automatic test_mid_reset();
    int cyc, hc;
    reset_dut();
    log_words.delete();
    log_rc.delete();
    reset_n = 1'b1;
    for (int i = 0; i < 200 && log_words.size() < 5; i++) begin
      @(negedge clk); #1;
    end
    checks++; if (log_words.size() !== 5) begin failures++; $display("FAIL mr_reach_e4 got=%0d want=5", log_words.size()); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1 || entry_idx !== 4'd4) begin failures++; $display("FAIL mr_pre busy=%b idx=%0d want 1/4", busy, entry_idx); end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.cmd_valid !== 1'b0 || bus.cmd_word !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 ||
                  error !== 1'b0 || entry_idx !== 4'd0 || retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL mr_reset_vals v=%b w=%h b=%b d=%b e=%b i=%0d r=%0d want all zero",
               bus.cmd_valid, bus.cmd_word, busy, done, error, entry_idx, retry_cnt);
    end
    // start at cycle 30 arrives mid-sequence and must not disturb it.
    run_seq(30, cyc, hc);
    checks++; if (cyc !== 145 || done !== 1'b1) begin failures++; $display("FAIL mr_rerun got=%0d done=%b want=145 done=1", cyc, done); end
    checks++; if (log_words.size() !== 9) begin failures++; $display("FAIL mr_count got=%0d want=9", log_words.size()); end
    for (int i = 0; i < 9 && i < log_words.size(); i++) begin
      checks++; if (log_words[i] !== exp_tab[i]) begin failures++; $display("FAIL mr_word[%0d] got=%h want=%h", i, log_words[i], exp_tab[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_back_to_back();
    test_nack_retry();
    test_abort();
    test_timeout();
    test_ready_hold();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
Sequences the WM8731 register writes that set the codec up for microphone capture. It replaces the fixed power-up write list and adds restart, retry and error reporting. It walks a constant write table and issues one 16-bit command per entry to the existing i2c_master through a valid/ready handshake. It then waits for the ACK/NACK result and retries or aborts as required. It runs in the i2c_clk domain (20 kHz); top_level uses done/error for LEDR status and holds the audio path until done.

Parameters:
NUM_WRITES, 9, entries in the write table; must equal the package table length.
MAX_RETRIES, 3, re-sends allowed per entry after NACK/timeout before abort.
GAP_CYCLES, 4, idle clk cycles between a completed write and the next command.
TIMEOUT_CYCLES, 64, clk cycles waited for ack_valid before treating the write as NACK.

Ports:
clk  in  1  i2c_clk, 20 kHz.
reset_n  in  1  synchronous, active-low reset.
start  in  1  single-cycle pulse; begins or restarts the sequence when not busy.
cmd_valid  out  1  command offered to i2c_master.
cmd_ready  in  1  i2c_master accepts command.
cmd_dev_addr  out  7  fixed 7'h1A (WM8731, write address 8'h34).
cmd_word  out  16  {reg_addr[6:0], reg_data[8:0]}.
ack_valid  in  1  single-cycle result pulse from i2c_master.
ack_nack  in  1  qualified by ack_valid; 1 = NACK.
busy  out  1  sequence in progress.
done  out  1  all entries written; sticky until next start or reset.
error  out  1  aborted; sticky until next start or reset.
entry_idx  out  4  current or failing table index.
retry_cnt  out  2  retries used on the current entry.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE, cmd_valid=0, cmd_word=0, busy=0, done=0, error=0, entry_idx=0, retry_cnt=0, timers 0. Applies mid-transfer; the i2c_master is reset by the same signal.
- Auto-start: the first cycle after reset is released behaves as a start pulse, so the codec is configured at power-up.
- IDLE/DONE/ERROR + start: clear done, error, entry_idx and retry_cnt; go to LOAD. start while busy is ignored.
- LOAD (1 cycle): cmd_word <= table[entry_idx]; go to SEND.
- SEND: cmd_valid=1 and cmd_word stable until the cmd_valid&cmd_ready cycle.
  - On acceptance: cmd_valid=0 the next cycle, timer cleared, go to WAIT_ACK.
  - No timeout is applied in SEND.
- WAIT_ACK, timer counts each cycle:
  - ack_valid & !ack_nack: go to GAP and set retry_cnt=0.
  - ack_valid & ack_nack, or timer reaches TIMEOUT_CYCLES-1 with no ack: if retry_cnt<MAX_RETRIES, increment retry_cnt and go to GAP then re-send the same entry. Otherwise go to ERROR with entry_idx holding the failing entry.
  - If ack_valid and timeout land on the same cycle, ack_valid wins.
- GAP: wait exactly GAP_CYCLES cycles, then act.
  - Entry succeeded and entry_idx==NUM_WRITES-1: go to DONE.
  - Entry succeeded otherwise: increment entry_idx and go to LOAD.
  - Retry pending: go to LOAD with entry_idx unchanged.
- DONE: done=1, busy=0. ERROR: error=1, busy=0. done and error are never both 1.
- busy=1 in LOAD/SEND/WAIT_ACK/GAP.
- ack_valid outside WAIT_ACK is ignored.
- Latency with an ideal master (cmd_ready=1, ack after k cycles): per entry = 1 LOAD + 1 SEND + k + GAP_CYCLES cycles.

Decomposition:
- Package codec_cfg_pkg holds:
  - State enum cfg_state_t (IDLE, LOAD, SEND, WAIT_ACK, GAP, DONE, ERROR).
  - WM8731_DEV_ADDR = 7'h1A.
  - Table entry typedef {logic [6:0] addr; logic [8:0] data}.
  - Constant array WM8731_CFG_TABLE, in this order:
    - R15=0x000 (reset)
    - R0=0x017, R1=0x017 (line-in levels)
    - R4=0x015 (mic select, boost, bypass off)
    - R5=0x000 (digital path)
    - R6=0x000 (power up all)
    - R7=0x042 (master, I2S, 16-bit)
    - R8=0x000 (sampling control)
    - R9=0x001 (active)
- Sub-module cfg_wait_timer: a loadable down-counter shared by the GAP and timeout waits, with load, value and expired outputs.
- FSM and datapath stay in codec_config_sequencer.

Test Plan:
- Reset release, master with cmd_ready=1 and ACK 10 cycles after accept -> 9 commands issued in order, first cmd_word=16'h1E00, last 16'h1201; done=1, error=0 after 9*(1+1+10+4)=144 cycles.
- NACK on entry 3 twice, then ACK -> entry 3 sent 3 times; retry_cnt reads 1 then 2 then 0; sequence completes with done=1.
- Entry 5 always NACKs -> 4 transmissions of 16'h0C00, then error=1, entry_idx=5, busy=0, cmd_valid=0; no entry 6 is issued.
- No ack_valid after accept -> timeout at 64 cycles is counted as a retry; after 4 attempts error=1; an ack_valid pulse arriving in GAP is ignored.
- cmd_ready held low 20 cycles -> cmd_valid stays 1 and cmd_word stays stable for all 20 cycles; no timeout fires.
- reset_n low for 1 cycle during WAIT_ACK of entry 4 -> all outputs return to reset values the next cycle; the auto-start re-runs the sequence from entry 0. A start pulse while busy is ignored.
